// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns and capture FSM states shared by the seven-segment encoder and capture logic.
package seg_pkg;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_TABLE [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                                              SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};
    typedef enum logic [1:0] {COLLECT, CONVERT, PUBLISH} state_t;
endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low G..A pattern to a BCD digit, flagging blank and unknown patterns.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       err
);
    always_comb begin
        digit = 4'hF;
        blank = seg == SEG_BLANK[6:0];
        for (int i = 0; i < 10; i++)
            if (seg == SEG_TABLE[i][6:0]) digit = 4'(i);
        if (blank) digit = 4'd0;
        err = digit == 4'hF;
    end
endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture: rebuilds a multiplexed seven-segment display into BCD/binary frames
// from debounced segment and digit-select samples.
module seg_display_capture
    import seg_pkg::*;
#(
    parameter int         SYNC_STAGES   = 2,
    parameter int         STABLE_CYCLES = 4,
    parameter logic [3:0] DIGIT_MASK    = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_data,
    input  logic [3:0]  an,
    output logic [15:0] value_bcd,
    output logic [13:0] value_bin,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_err,
    output logic        frame_valid
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    logic [11:0]   sync_q [SYNC_STAGES];
    logic [11:0]   smp, prev;
    logic [CW-1:0] cnt;
    logic [3:0]    dec_digit, cap_vec, cap_mask, dp_sh, blank_sh, err_sh;
    logic          dec_blank, dec_err, capture, full;
    logic [15:0]   dig_sh, nib_mask, snap_bcd;
    logic [3:0]    snap_dp, snap_blank, snap_err, cur, add;
    logic [1:0]    k;
    logic [13:0]   acc;
    state_t        state;

    assign smp = sync_q[SYNC_STAGES-1];
    seg_pattern_decode u_dec (.seg(smp[6:0]), .digit(dec_digit), .blank(dec_blank), .err(dec_err));
    // The counter saturates, so a long stable run captures only once.
    assign capture = (smp == prev) && (cnt == CW'(STABLE_CYCLES - 1)) && $onehot(~smp[11:8]);
    assign cap_vec = capture ? ~smp[11:8] : 4'b0;
    assign full    = (cap_mask & DIGIT_MASK) == DIGIT_MASK;
    assign cur     = snap_bcd[4*k +: 4];
    assign add     = (cur > 4'd9) ? 4'd0 : cur;

    always_comb begin
        nib_mask = '0;
        for (int i = 0; i < 4; i++) nib_mask[4*i +: 4] = {4{DIGIT_MASK[i]}};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
            cnt  <= '0;
        end else begin
            sync_q[0] <= {an, seg_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= smp;
            cnt  <= (smp != prev) ? CW'(1) : (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
        end

    // A capture coinciding with the snapshot survives the mask clear and counts toward the next frame.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dig_sh   <= '0;
            dp_sh    <= '0;
            blank_sh <= '0;
            err_sh   <= '0;
            cap_mask <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (cap_vec[i]) begin
                    dig_sh[4*i +: 4] <= dec_digit;
                    dp_sh[i]         <= ~smp[7];
                    blank_sh[i]      <= dec_blank;
                    err_sh[i]        <= dec_err;
                end
            cap_mask <= ((state == COLLECT && full) ? 4'b0 : cap_mask) | cap_vec;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= COLLECT;
            k           <= '0;
            acc         <= '0;
            snap_bcd    <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_err    <= '0;
            value_bcd   <= '0;
            value_bin   <= '0;
            dp          <= '0;
            blank       <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                COLLECT:
                    if (full) begin
                        snap_bcd   <= dig_sh & nib_mask;
                        snap_dp    <= dp_sh & DIGIT_MASK;
                        snap_blank <= blank_sh & DIGIT_MASK;
                        snap_err   <= err_sh & DIGIT_MASK;
                        acc        <= '0;
                        k          <= 2'd3;
                        state      <= CONVERT;
                    end
                CONVERT: begin
                    acc <= acc * 14'd10 + {10'd0, add};
                    k   <= k - 2'd1;
                    if (k == 2'd0) state <= PUBLISH;
                end
                PUBLISH: begin
                    value_bcd   <= snap_bcd;
                    value_bin   <= acc;
                    dp          <= snap_dp;
                    blank       <= snap_blank;
                    frame_err   <= |snap_err;
                    frame_valid <= 1'b1;
                    state       <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
endmodule
